out_display: RTL and testbench
==============================

OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 Parameter SCAN_DIV, default 1024: clock cycles per display digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 shows all three digits.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 din  input  8  unsigned value from the output register.
REQ-006 ld  input  1  active-high load strobe, sampled on posedge clk.
REQ-007 busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-008 bcd  output  12  last converted value: {hundreds, tens, units}, 4 bits each.
REQ-009 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
REQ-010 low_dig_en  output  3  digit enables, active-low; bit 0 units, bit 1 tens, bit 2 hundreds.

Function
REQ-011 The FSM SHALL have two states: IDLE and CONVERT.
REQ-012 In IDLE, ld=1 at edge E0 SHALL capture din into a shift register, clear the BCD scratch register, enter CONVERT, and set busy=1 after E0.
REQ-013 In CONVERT, each of edges E1..E8 SHALL perform one double-dabble step: add 3 to any scratch BCD nibble >= 5, then shift {scratch, shift register} left by 1.
REQ-014 At E8, bcd SHALL load the final scratch value, busy SHALL return to 0, and the FSM SHALL return to IDLE; latency from ld to valid bcd is exactly 8 cycles.
REQ-015 bcd SHALL hold its value between conversions; it SHALL not show intermediate scratch values.
REQ-016 ld sampled while in CONVERT, including at E8, SHALL be ignored; no queueing.
REQ-017 din SHALL only be sampled at E0; changes during CONVERT have no effect.
REQ-018 A scan counter SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the digit index SHALL advance units -> tens -> hundreds -> units.
REQ-019 The scan counter and digit index SHALL run continuously, independent of busy and ld.
REQ-020 Exactly one bit of low_dig_en SHALL be low at all times, and it SHALL match the digit index.
REQ-021 seg SHALL be a registered decode of the bcd nibble selected by the digit index, updated on the same edge as the digit index.
REQ-022 Segment codes SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-023 Nibble values 10..15 cannot occur; if forced, seg SHALL be 1000000 (dash).
REQ-024 With BLANK_LZ=1, seg SHALL be 0000000 for hundreds when hundreds=0, and for tens when hundreds=0 and tens=0; units SHALL never be blanked.
REQ-025 When a new bcd value loads, it SHALL be visible from the next digit slot; the scan position SHALL not reset.

Reset
REQ-026 While clr=0: FSM=IDLE, busy=0, bcd=12'h000, shift and scratch registers=0, scan counter=0, digit index=units, low_dig_en=3'b110, seg=0111111.
REQ-027 clr asserted during CONVERT SHALL abort the conversion; bcd SHALL be 0, not a partial result.
REQ-028 After clr deasserts, the first posedge SHALL be a normal IDLE cycle; ld at that edge SHALL be accepted.

Verification
REQ-029 Reset, then ld with din=8'd255 -> busy high for 8 cycles; at E8 bcd=12'h255 and busy=0.
REQ-030 ld with din=8'd0, then din=8'd100, then din=8'd99 -> bcd=12'h000, 12'h100, 12'h099 respectively.
REQ-031 BLANK_LZ=1, SCAN_DIV=4, din=8'd7 -> over 12 cycles: units seg=0000111; tens and hundreds slots seg=0000000; low_dig_en sequence is 110, 101, 011, with each value held 4 cycles.
REQ-032 ld din=8'd42 at E0, then ld din=8'd13 at E3 and at E8 -> bcd=12'h042 only; busy=0 after E8.
REQ-033 ld din=8'd200, clr pulsed low at E4 -> immediately busy=0, bcd=12'h000, low_dig_en=110; ld din=8'd5 on the first edge after release -> bcd=12'h005 eight cycles later.
REQ-034 BLANK_LZ=0, din=8'd5 -> hundreds and tens slots show seg=0111111.

Source files
------------

// File: rtl/out_display.sv
// out_display: 8-bit value to three-digit multiplexed 7-segment display.
// A double-dabble FSM converts a loaded byte to BCD in 8 cycles, and a free
// running scan walks units -> tens -> hundreds, driving one digit per slot.

// Per-digit segment decoder: nibble to {g,f,e,d,c,b,a}, with blanking.
module out_display_seg (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] code
);
    // Digits 0..9 decode normally; anything above 9 shows a dash.
    always_comb begin
        code = 7'b1000000;
        if (blank) begin
            code = 7'b0000000;
        end else begin
            case (nib)
                4'd0:    code = 7'b0111111;
                4'd1:    code = 7'b0000110;
                4'd2:    code = 7'b1011011;
                4'd3:    code = 7'b1001111;
                4'd4:    code = 7'b1100110;
                4'd5:    code = 7'b1101101;
                4'd6:    code = 7'b1111101;
                4'd7:    code = 7'b0000111;
                4'd8:    code = 7'b1111111;
                4'd9:    code = 7'b1101111;
                default: code = 7'b1000000;
            endcase
        end
    end
endmodule

module out_display #(
    parameter int SCAN_DIV = 1024,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  din,
    input  logic        ld,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  low_dig_en
);
    localparam int NUM_DIG = 3;
    localparam int CW      = $clog2(SCAN_DIV);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                      state;
    logic [7:0]                  sh;
    logic [NUM_DIG-1:0][3:0]     scr;
    logic [NUM_DIG-1:0][3:0]     adj;
    logic [NUM_DIG-1:0][3:0]     scr_nx;
    logic [7:0]                  sh_nx;
    logic [2:0]                  step;
    logic [NUM_DIG-1:0][3:0]     bcd_r;

    logic [CW-1:0]               scan_cnt;
    logic [NUM_DIG-1:0]          dig_sel;
    logic [NUM_DIG-1:0]          dig_nx;
    logic [NUM_DIG-1:0]          blank;
    logic [NUM_DIG-1:0][6:0]     dec;
    logic [6:0]                  seg_nx;

    assign bcd        = bcd_r;
    assign low_dig_en = ~dig_sel;

    // Add-3 correction on every scratch nibble that would overflow on shift.
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
        assign adj[g] = (scr[g] >= 4'd5) ? scr[g] + 4'd3 : scr[g];
    end

    // One double-dabble step: shift {adjusted scratch, shift reg} left by 1.
    always_comb begin
        {scr_nx, sh_nx} = {adj, sh} << 1;
    end

    // Conversion FSM; bcd only ever takes the completed result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            busy  <= 1'b0;
            sh    <= '0;
            scr   <= '0;
            step  <= '0;
            bcd_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld) begin
                        sh    <= din;
                        scr   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    sh   <= sh_nx;
                    scr  <= scr_nx;
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        bcd_r <= scr_nx;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Leading-zero blanking: hundreds if zero, tens if hundreds and tens zero.
    always_comb begin
        blank    = '0;
        blank[2] = (BLANK_LZ != 0) && (bcd_r[2] == 4'd0);
        blank[1] = (BLANK_LZ != 0) && (bcd_r[2] == 4'd0) && (bcd_r[1] == 4'd0);
    end

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
        out_display_seg u_seg (
            .nib   (bcd_r[g]),
            .blank (blank[g]),
            .code  (dec[g])
        );
    end

    // Next digit select and the code that digit will show.
    always_comb begin
        dig_nx = {dig_sel[NUM_DIG-2:0], dig_sel[NUM_DIG-1]};
        seg_nx = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_nx[i]) seg_nx = seg_nx | dec[i];
        end
    end

    // Free-running scan; digit and its segments change together on wrap.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scan_cnt <= '0;
            dig_sel  <= 3'b001;
            seg      <= 7'b0111111;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_sel  <= dig_nx;
            seg      <= seg_nx;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_out_display.sv
// Bench for out_display: two instances (blanking on, SCAN_DIV=4; blanking off,
// SCAN_DIV=5) share stimulus. A decimal-arithmetic model predicts every cycle,
// and a scoreboard checks each finished conversion and its duration.
module tb_out_display;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        ld  = 1'b0;
    logic [7:0]  din = 8'd0;

    logic        busy_a, busy_b;
    logic [11:0] bcd_a, bcd_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  len_a, len_b;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] SEG_TBL [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011,
        7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111,
        7'b1101111};
    localparam int SDS [0:1] = '{4, 5};
    localparam bit BLK [0:1] = '{1'b1, 1'b0};

    out_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .clr(clr), .din(din), .ld(ld),
        .busy(busy_a), .bcd(bcd_a), .seg(seg_a), .low_dig_en(len_a)
    );
    out_display #(.SCAN_DIV(5), .BLANK_LZ(0)) dut_b (
        .clk(clk), .clr(clr), .din(din), .ld(ld),
        .busy(busy_b), .bcd(bcd_b), .seg(seg_b), .low_dig_en(len_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(int slot, int v, bit blk);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (slot == 0) return SEG_TBL[u];
        if (slot == 1) return (blk && h == 0 && t == 0) ? 7'd0 : SEG_TBL[t];
        return (blk && h == 0) ? 7'd0 : SEG_TBL[h];
    endfunction

    function automatic logic [2:0] exp_len(int slot);
        if (slot == 0) return 3'b110;
        if (slot == 1) return 3'b101;
        return 3'b011;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: decimal value on display, cycles left in conversion,
    // scan slot per instance derived from edges since reset.
    int         m_val   = 0;
    int         m_pend  = 0;
    int         m_left  = 0;
    int         m_edges = 0;
    int         m_slot [0:1] = '{0, 0};
    logic [6:0] m_seg  [0:1] = '{7'b0111111, 7'b0111111};
    int         sb [$];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_val = 0; m_pend = 0; m_left = 0; m_edges = 0;
            for (int k = 0; k < 2; k++) begin
                m_slot[k] = 0;
                m_seg[k]  = 7'b0111111;
            end
            sb.delete();
        end else begin
            m_edges++;
            for (int k = 0; k < 2; k++) begin
                if (m_edges % SDS[k] == 0) begin
                    m_slot[k] = (m_slot[k] + 1) % 3;
                    m_seg[k]  = exp_seg(m_slot[k], m_val, BLK[k]);
                end
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_val = m_pend;
            end else if (ld) begin
                m_pend = int'(din);
                m_left = 8;
                sb.push_back(int'(din));
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy_a", busy_a, m_left > 0);
        chk("busy_b", busy_b, m_left > 0);
        chk("bcd_a", bcd_a, to_bcd(m_val));
        chk("bcd_b", bcd_b, to_bcd(m_val));
        chk("len_a", len_a, exp_len(m_slot[0]));
        chk("len_b", len_b, exp_len(m_slot[1]));
        chk("seg_a", seg_a, m_seg[0]);
        chk("seg_b", seg_b, m_seg[1]);
    end

    // Scoreboard monitor: on each completed conversion pop the expected value.
    bit prev_busy = 1'b0;
    int hi_cnt    = 0;
    always @(negedge clk) begin
        if (!clr) begin
            prev_busy = 1'b0;
            hi_cnt    = 0;
        end else begin
            if (busy_a) hi_cnt++;
            if (prev_busy && !busy_a) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got result %0h want none", bcd_a);
                end else begin
                    int e;
                    e = sb.pop_front();
                    chk("sb_bcd_a", bcd_a, to_bcd(e));
                    chk("sb_bcd_b", bcd_b, to_bcd(e));
                    chk("busy_len", hi_cnt, 8);
                end
                hi_cnt = 0;
            end
            prev_busy = busy_a;
        end
    end

    task automatic cyc(input bit l, input logic [7:0] d);
        @(posedge clk);
        #2;
        ld  = l;
        din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 clr = 1'b1;

        cyc(1'b1, 8'd255); idle(10);
        cyc(1'b1, 8'd0);   idle(9);
        cyc(1'b1, 8'd100); idle(9);
        cyc(1'b1, 8'd99);  idle(9);
        cyc(1'b1, 8'd7);   idle(14);
        cyc(1'b1, 8'd5);   idle(20);

        // Loads at E3 and E8 of a running conversion are dropped.
        cyc(1'b1, 8'd42);
        cyc(1'b0, 8'd0); cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd13);
        repeat (4) cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd13);
        idle(10);

        // Abort mid-conversion, then load on the first edge after release.
        cyc(1'b1, 8'd200);
        repeat (3) cyc(1'b0, 8'd0);
        @(posedge clk); #2 clr = 1'b0;
        @(posedge clk); #2 clr = 1'b1; ld = 1'b1; din = 8'd5;
        cyc(1'b0, 8'd77);
        idle(12);

        repeat (400) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                @(posedge clk); #2 clr = 1'b0; ld = 1'b0;
                @(posedge clk); #2 clr = 1'b1;
            end else begin
                cyc(r < 30, 8'($urandom));
            end
        end
        idle(12);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
